srcnn_mul_acc_pipe: RTL

SRCNN_MUL_ACC_PIPE -- requirements
Module: srcnn_mul_acc_pipe

---
 rtl/srcnn_mul_acc_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/srcnn_mul_acc_pipe.sv
// Pipelined multiply-accumulate with valid/ready handshake.
// Supports per-beat signed/unsigned operands, with wrap or clamp on overflow.
module srcnn_mul_acc_pipe #(
   parameter int DIN0_WIDTH = 5,
   parameter int DIN1_WIDTH = 6,
   parameter int ACC_WIDTH  = 16,
   parameter int NUM_STAGE  = 2,
   parameter int SATURATE   = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic                  in_signed,
   input  logic                  in_first,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  dout,
   output logic                  ovf
);

   localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;
   localparam int SW = ((PW > ACC_WIDTH) ? PW : ACC_WIDTH) + 2;
   localparam int L  = NUM_STAGE - 1;

   logic                 en;
   logic signed [SW-1:0] ax;
   logic signed [SW-1:0] bx;
   logic signed [SW-1:0] prod;
   logic signed [SW-1:0] p_q [NUM_STAGE];
   logic [NUM_STAGE-1:0] v_q;
   logic [NUM_STAGE-1:0] f_q;
   logic [NUM_STAGE-1:0] l_q;
   logic [NUM_STAGE-1:0] s_q;

   logic [ACC_WIDTH-1:0] acc;
   logic                 acc_ovf;
   logic signed [SW-1:0] base;
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] lim_hi;
   logic signed [SW-1:0] lim_lo;
   logic                 over;
   logic [ACC_WIDTH-1:0] acc_nx;
   logic                 ovf_nx;

   assign in_ready = !out_valid || out_ready;
   assign en       = in_ready;

   always_comb begin
      ax   = {{(SW-DIN0_WIDTH){in_signed & din0[DIN0_WIDTH-1]}}, din0};
      bx   = {{(SW-DIN1_WIDTH){in_signed & din1[DIN1_WIDTH-1]}}, din1};
      prod = ax * bx;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         v_q <= '0;
         f_q <= '0;
         l_q <= '0;
         s_q <= '0;
         for (int i = 0; i < NUM_STAGE; i++) p_q[i] <= '0;
      end else if (en) begin
         v_q[0] <= in_valid;
         f_q[0] <= in_first;
         l_q[0] <= in_last;
         s_q[0] <= in_signed;
         p_q[0] <= prod;
         for (int i = 1; i < NUM_STAGE; i++) begin
            v_q[i] <= v_q[i-1];
            f_q[i] <= f_q[i-1];
            l_q[i] <= l_q[i-1];
            s_q[i] <= s_q[i-1];
            p_q[i] <= p_q[i-1];
         end
      end
   end

   // Range limits follow the signedness of the term being added.
   always_comb begin
      base = '0;
      if (!f_q[L]) begin
         if (s_q[L]) base = {{(SW-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
         else        base = {{(SW-ACC_WIDTH){1'b0}}, acc};
      end
      sum = base + p_q[L];
      if (s_q[L]) begin
         lim_hi = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
         lim_lo = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
      end else begin
         lim_hi = {{(SW-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};
         lim_lo = '0;
      end
      over   = (sum > lim_hi) || (sum < lim_lo);
      acc_nx = sum[ACC_WIDTH-1:0];
      if (SATURATE != 0 && over) begin
         if (sum > lim_hi) acc_nx = lim_hi[ACC_WIDTH-1:0];
         else              acc_nx = lim_lo[ACC_WIDTH-1:0];
      end
      ovf_nx = (!f_q[L] && acc_ovf) || over;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc       <= '0;
         acc_ovf   <= 1'b0;
         out_valid <= 1'b0;
         dout      <= '0;
         ovf       <= 1'b0;
      end else begin
         if (en && v_q[L]) begin
            if (l_q[L]) begin
               acc     <= '0;
               acc_ovf <= 1'b0;
            end else begin
               acc     <= acc_nx;
               acc_ovf <= ovf_nx;
            end
         end
         if (en && v_q[L] && l_q[L]) begin
            out_valid <= 1'b1;
            dout      <= acc_nx;
            ovf       <= ovf_nx;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
